// File: rtl/demux_tdm.sv
// 1-to-LANES time-division demultiplexer: manual steering via sel, or a
// frame-locked mode that assembles whole frames in a shadow buffer.
module demux_tdm #(
    parameter int LANES = 4,
    parameter int SEL_W = 2,
    parameter int WIDTH = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic [WIDTH-1:0]       in_data,
    input  logic                   frame_sync,
    input  logic                   auto_mode,
    input  logic [SEL_W-1:0]       sel,
    output logic [LANES*WIDTH-1:0] out,
    output logic                   out_valid,
    output logic [LANES-1:0]       lane_strobe,
    output logic                   sync_err
);

    localparam logic [0:0] HUNT   = 1'b0;
    localparam logic [0:0] LOCKED = 1'b1;

    localparam logic [SEL_W-1:0] LAST_LANE = SEL_W'(LANES - 1);
    localparam logic [SEL_W-1:0] ONE       = SEL_W'(1);

    logic [0:0]                 state;
    logic [SEL_W-1:0]           cnt;
    // The last lane of a frame goes straight to out, so only LANES-1 are buffered.
    logic [(LANES-1)*WIDTH-1:0] shadow;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= HUNT;
            cnt         <= '0;
            shadow      <= '0;
            out         <= '0;
            out_valid   <= 1'b0;
            lane_strobe <= '0;
            sync_err    <= 1'b0;
        end else begin
            out_valid   <= 1'b0;
            lane_strobe <= '0;
            sync_err    <= 1'b0;

            if (!auto_mode) begin
                state <= HUNT;
                cnt   <= '0;
                if (in_valid) begin
                    out[sel*WIDTH +: WIDTH] <= in_data;
                    lane_strobe             <= LANES'(1) << sel;
                end
            end else if (in_valid) begin
                case (state)
                    HUNT: begin
                        if (frame_sync) begin
                            shadow[WIDTH-1:0] <= in_data;
                            cnt               <= ONE;
                            state             <= LOCKED;
                        end
                    end
                    default: begin
                        if (frame_sync) begin
                            // A sync mid-frame abandons the partial frame and restarts on this sample.
                            sync_err          <= (cnt != '0);
                            shadow[WIDTH-1:0] <= in_data;
                            cnt               <= ONE;
                        end else if (cnt == LAST_LANE) begin
                            out       <= {in_data, shadow};
                            out_valid <= 1'b1;
                            cnt       <= '0;
                        end else begin
                            shadow[cnt*WIDTH +: WIDTH] <= in_data;
                            cnt                        <= cnt + ONE;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_demux_tdm.sv
// Bench for demux_tdm: directed scenarios plus random traffic, checked every
// cycle against a frame-queue model of the demultiplexer.
module tb_demux_tdm;

    localparam int LANES = 4;
    localparam int SEL_W = 2;
    localparam int WIDTH = 1;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   in_valid = 1'b0;
    logic [WIDTH-1:0]       in_data = '0;
    logic                   frame_sync = 1'b0;
    logic                   auto_mode = 1'b0;
    logic [SEL_W-1:0]       sel = '0;
    logic [LANES*WIDTH-1:0] out;
    logic                   out_valid;
    logic [LANES-1:0]       lane_strobe;
    logic                   sync_err;

    int total = 0;
    int bad   = 0;

    demux_tdm #(.LANES(LANES), .SEL_W(SEL_W), .WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .frame_sync (frame_sync),
        .auto_mode  (auto_mode),
        .sel        (sel),
        .out        (out),
        .out_valid  (out_valid),
        .lane_strobe(lane_strobe),
        .sync_err   (sync_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a frame is simply the list of samples collected since the last sync.
    logic [LANES*WIDTH-1:0] exp_out = '0;
    logic                   exp_valid = 1'b0;
    logic [LANES-1:0]       exp_strobe = '0;
    logic                   exp_err = 1'b0;
    bit                     locked = 1'b0;
    bit                     armed = 1'b0;
    logic [WIDTH-1:0]       frame[$];

    always @(posedge clk) begin
        exp_valid  = 1'b0;
        exp_strobe = '0;
        exp_err    = 1'b0;
        if (rst) begin
            exp_out = '0;
            locked  = 1'b0;
            frame.delete();
        end else if (!auto_mode) begin
            locked = 1'b0;
            frame.delete();
            if (in_valid) begin
                exp_out[int'(sel)*WIDTH +: WIDTH] = in_data;
                exp_strobe[sel] = 1'b1;
            end
        end else if (in_valid) begin
            if (frame_sync) begin
                if (locked && frame.size() != 0) exp_err = 1'b1;
                frame.delete();
                frame.push_back(in_data);
                locked = 1'b1;
            end else if (locked) begin
                frame.push_back(in_data);
                if (frame.size() == LANES) begin
                    for (int k = 0; k < LANES; k++) exp_out[k*WIDTH +: WIDTH] = frame[k];
                    exp_valid = 1'b1;
                    frame.delete();
                end
            end
        end
        armed = 1'b1;
    end

    always @(negedge clk) begin
        if (armed) begin
            check("out", 32'(out), 32'(exp_out));
            check("out_valid", 32'(out_valid), 32'(exp_valid));
            check("lane_strobe", 32'(lane_strobe), 32'(exp_strobe));
            check("sync_err", 32'(sync_err), 32'(exp_err));
        end
    end

    // Apply one cycle of inputs; returns just after the capturing edge.
    task automatic step(input logic r, input logic v, input logic [WIDTH-1:0] d,
                        input logic fs, input logic am, input logic [SEL_W-1:0] s);
        @(negedge clk);
        rst        = r;
        in_valid   = v;
        in_data    = d;
        frame_sync = fs;
        auto_mode  = am;
        sel        = s;
        @(posedge clk);
        #1;
    endtask

    task automatic samp(input logic [WIDTH-1:0] d, input logic fs, input logic am);
        step(1'b0, 1'b1, d, fs, am, '0);
    endtask

    task automatic idle(input int n, input logic am);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, 1'b0, am, '0);
    endtask

    initial begin
        // Reset held two clocks with live input traffic
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'd1);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2'd2);
        check("rst_out", 32'(out), 32'h0);
        check("rst_strobe", 32'(lane_strobe), 32'h0);

        // Manual steering: lane k gets bit k of 4'b1100
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
        check("man_strobe0", 32'(lane_strobe), 32'b0001);
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd1);
        check("man_strobe1", 32'(lane_strobe), 32'b0010);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd2);
        check("man_strobe2", 32'(lane_strobe), 32'b0100);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd3);
        check("man_strobe3", 32'(lane_strobe), 32'b1000);
        check("man_out", 32'(out), 32'b1100);

        // Auto lock: pre-sync samples dropped, frame 1,1,0,0 -> 0011
        samp(1'b1, 1'b0, 1'b1);
        samp(1'b0, 1'b0, 1'b1);
        samp(1'b1, 1'b1, 1'b1);
        samp(1'b1, 1'b0, 1'b1);
        samp(1'b0, 1'b0, 1'b1);
        check("lock_hold", 32'(out), 32'b1100);
        samp(1'b0, 1'b0, 1'b1);
        check("lock_valid", 32'(out_valid), 32'h1);
        check("lock_out", 32'(out), 32'b0011);
        check("lock_strobe", 32'(lane_strobe), 32'h0);

        // Back-to-back frames with gaps
        samp(1'b1, 1'b1, 1'b1); idle(2, 1'b1);
        samp(1'b1, 1'b0, 1'b1); idle(1, 1'b1);
        samp(1'b0, 1'b0, 1'b1);
        samp(1'b0, 1'b0, 1'b1);
        check("b2b_valid1", 32'(out_valid), 32'h1);
        samp(1'b0, 1'b1, 1'b1); idle(1, 1'b1);
        samp(1'b1, 1'b0, 1'b1);
        samp(1'b0, 1'b0, 1'b1); idle(3, 1'b1);
        check("b2b_hold", 32'(out), 32'b0011);
        samp(1'b1, 1'b0, 1'b1);
        check("b2b_valid2", 32'(out_valid), 32'h1);
        check("b2b_out", 32'(out), 32'b1010);

        // Sync on third sample of a frame
        samp(1'b1, 1'b1, 1'b1);
        samp(1'b1, 1'b0, 1'b1);
        samp(1'b0, 1'b1, 1'b1);
        check("serr_pulse", 32'(sync_err), 32'h1);
        check("serr_novalid", 32'(out_valid), 32'h0);
        check("serr_out", 32'(out), 32'b1010);
        samp(1'b1, 1'b0, 1'b1);
        check("serr_clear", 32'(sync_err), 32'h0);
        samp(1'b1, 1'b0, 1'b1);
        samp(1'b0, 1'b0, 1'b1);
        check("serr_recover", 32'(out), 32'b0110);
        check("serr_rvalid", 32'(out_valid), 32'h1);

        // Mode drop mid-frame, then re-entry must hunt for sync
        samp(1'b1, 1'b1, 1'b1);
        samp(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd3);
        check("drop_strobe", 32'(lane_strobe), 32'b1000);
        check("drop_out", 32'(out), 32'b1110);
        for (int i = 0; i < 5; i++) begin
            samp(1'b1, 1'b0, 1'b1);
            check("hunt_novalid", 32'(out_valid), 32'h0);
        end
        check("hunt_out", 32'(out), 32'b1110);
        samp(1'b0, 1'b1, 1'b1);
        samp(1'b0, 1'b0, 1'b1);
        samp(1'b0, 1'b0, 1'b1);
        samp(1'b1, 1'b0, 1'b1);
        check("relock_out", 32'(out), 32'b1000);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 3) != 0),
                 WIDTH'($urandom),
                 ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 9) != 0),
                 SEL_W'($urandom));
        end
        idle(2, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
